multicycle_seq_ctrl: RTL and testbench

- Multi-cycle sequencing controller for the 8-bit RISC core; splits each instruction into FETCH / DECODE / EXECUTE / WRITEBACK states.
- Adds an instruction-memory request/ready handshake.
- Adds run / single-step / halt control for debug.
- Provides a fetch-timeout fault and a retired-instruction counter.
- Drives the same PC, ALU, immediate-mux, register-file and branch-enable controls as the single-cycle decoder, but gated per state.

---
 rtl/multicycle_seq_ctrl.sv | 215 +++++++++++++++++++++
 tb/tb_multicycle_seq_ctrl.sv | 397 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_seq_ctrl.sv
// Multi-cycle sequencing controller for the 8-bit RISC core.
// FETCH/DECODE/EXECUTE/WRITEBACK with imem handshake and debug run control.
module multicycle_seq_ctrl #(
  parameter int MAX_WAIT = 15,
  parameter int CNT_W    = 16
) (
  input  logic             clock,
  input  logic             nReset,
  input  logic             run,
  input  logic             step,
  input  logic             halt_req,
  output logic             imem_req,
  input  logic             imem_ready,
  output logic             ir_load,
  input  logic [2:0]       opcode,
  input  logic             BLT,
  input  logic             BEQ,
  output logic             PCbranch,
  output logic             PCincr,
  output logic [2:0]       EXE_CMD,
  output logic             ImSel,
  output logic             Reg_w,
  output logic             branchEn,
  output logic             busy,
  output logic             fault,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] instr_count
);

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_SRL  = 3'd2;
  localparam logic [2:0] OP_ADDI = 3'd3;
  localparam logic [2:0] OP_SLLI = 3'd4;
  localparam logic [2:0] OP_BLT  = 3'd5;
  localparam logic [2:0] OP_BEQ  = 3'd6;
  localparam logic [2:0] OP_J    = 3'd7;

  localparam logic [2:0] ALU_NOP  = 3'd0;
  localparam logic [2:0] ALU_RADD = 3'd1;
  localparam logic [2:0] ALU_RSUB = 3'd2;
  localparam logic [2:0] ALU_RSRL = 3'd3;
  localparam logic [2:0] ALU_RSLL = 3'd4;

  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_WRITEBACK = 3'd4,
    S_FAULT     = 3'd5
  } state_t;

  state_t     state_q;
  logic [7:0] wait_cnt;

  logic [2:0] dec_alu;
  logic       dec_imm;
  logic       dec_wr;
  logic       dec_br;
  logic       take;

  assign state = state_q;

  // Opcode decode; opcode is stable from DECODE through WRITEBACK.
  always_comb begin
    dec_alu = ALU_NOP;
    dec_imm = 1'b0;
    dec_wr  = 1'b0;
    dec_br  = 1'b0;
    unique case (1'b1)
      (opcode == OP_ADD): begin
        dec_alu = ALU_RADD;
        dec_wr  = 1'b1;
      end
      (opcode == OP_SUB): begin
        dec_alu = ALU_RSUB;
        dec_wr  = 1'b1;
      end
      (opcode == OP_SRL): begin
        dec_alu = ALU_RSRL;
        dec_wr  = 1'b1;
      end
      (opcode == OP_ADDI): begin
        dec_alu = ALU_RADD;
        dec_imm = 1'b1;
        dec_wr  = 1'b1;
      end
      (opcode == OP_SLLI): begin
        dec_alu = ALU_RSLL;
        dec_imm = 1'b1;
        dec_wr  = 1'b1;
      end
      (opcode == OP_BLT),
      (opcode == OP_BEQ): begin
        dec_br = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // Branch resolution uses the ALU flags of the EXECUTE cycle itself.
  always_comb begin
    take = 1'b0;
    if (state_q == S_EXECUTE) begin
      take = (opcode == OP_J)
           | ((opcode == OP_BLT) & BLT)
           | ((opcode == OP_BEQ) & BEQ);
    end
  end

  assign PCbranch = take;
  assign ir_load  = (state_q == S_FETCH) & imem_ready;

  // Sequencer: outputs are registered for the state being entered.
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      state_q     <= S_IDLE;
      wait_cnt    <= 8'd0;
      instr_count <= '0;
      imem_req    <= 1'b0;
      EXE_CMD     <= ALU_NOP;
      ImSel       <= 1'b0;
      Reg_w       <= 1'b0;
      PCincr      <= 1'b0;
      branchEn    <= 1'b0;
      busy        <= 1'b0;
      fault       <= 1'b0;
    end else begin
      imem_req <= 1'b0;
      EXE_CMD  <= ALU_NOP;
      ImSel    <= 1'b0;
      Reg_w    <= 1'b0;
      PCincr   <= 1'b0;
      branchEn <= 1'b0;
      busy     <= 1'b0;
      fault    <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (!halt_req && (run || step)) begin
            state_q  <= S_FETCH;
            imem_req <= 1'b1;
            busy     <= 1'b1;
          end
        end
        S_FETCH: begin
          if (imem_ready) begin
            state_q  <= S_DECODE;
            wait_cnt <= 8'd0;
            busy     <= 1'b1;
          end else if (wait_cnt == WAIT_LAST) begin
            state_q  <= S_FAULT;
            wait_cnt <= 8'd0;
            fault    <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
            imem_req <= 1'b1;
            busy     <= 1'b1;
          end
        end
        S_DECODE: begin
          state_q  <= S_EXECUTE;
          busy     <= 1'b1;
          EXE_CMD  <= dec_alu;
          ImSel    <= dec_imm;
          branchEn <= dec_br;
        end
        S_EXECUTE: begin
          state_q <= S_WRITEBACK;
          busy    <= 1'b1;
          EXE_CMD <= EXE_CMD;
          ImSel   <= ImSel;
          Reg_w   <= dec_wr;
          // the PCincr register doubles as the not-taken flag
          PCincr  <= ~take;
        end
        S_WRITEBACK: begin
          instr_count <= instr_count + CNT_W'(1);
          if (halt_req) begin
            state_q <= S_IDLE;
          end else if (run) begin
            state_q  <= S_FETCH;
            imem_req <= 1'b1;
            busy     <= 1'b1;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_FAULT: begin
          fault <= 1'b1;
        end
        default: begin
          state_q  <= S_IDLE;
          wait_cnt <= 8'd0;
        end
      endcase
    end
  end

  a_pc_excl: assert property (
    @(posedge clock) disable iff (!nReset)
    !(PCincr && PCbranch));

  a_regw_wb: assert property (
    @(posedge clock) disable iff (!nReset)
    Reg_w |-> (state_q == S_WRITEBACK));

  a_fault_sticky: assert property (
    @(posedge clock) disable iff (!nReset)
    fault |=> fault);

endmodule

// File: tb/tb_multicycle_seq_ctrl.sv
// Bench for multicycle_seq_ctrl: random programs vs a
// per-instruction reference model, scoreboard-checked at WRITEBACK.
module tb_multicycle_seq_ctrl;

  localparam int MW = 15;
  localparam int CW = 4;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_SRL  = 3'd2;
  localparam logic [2:0] OP_ADDI = 3'd3;
  localparam logic [2:0] OP_SLLI = 3'd4;
  localparam logic [2:0] OP_BLT  = 3'd5;
  localparam logic [2:0] OP_BEQ  = 3'd6;
  localparam logic [2:0] OP_J    = 3'd7;

  localparam logic [2:0] ALU_NOP  = 3'd0;
  localparam logic [2:0] ALU_RADD = 3'd1;
  localparam logic [2:0] ALU_RSUB = 3'd2;
  localparam logic [2:0] ALU_RSRL = 3'd3;
  localparam logic [2:0] ALU_RSLL = 3'd4;

  logic          clock = 1'b0;
  logic          nReset = 1'b1;
  logic          run = 1'b0;
  logic          step = 1'b0;
  logic          halt_req = 1'b0;
  logic          imem_ready = 1'b1;
  logic [2:0]    opcode = 3'd0;
  logic          BLT = 1'b0;
  logic          BEQ = 1'b0;
  logic          imem_req;
  logic          ir_load;
  logic          PCbranch;
  logic          PCincr;
  logic [2:0]    EXE_CMD;
  logic          ImSel;
  logic          Reg_w;
  logic          branchEn;
  logic          busy;
  logic          fault;
  logic [2:0]    state;
  logic [CW-1:0] instr_count;

  multicycle_seq_ctrl #(.MAX_WAIT(MW), .CNT_W(CW)) dut (
    .clock(clock), .nReset(nReset),
    .run(run), .step(step), .halt_req(halt_req),
    .imem_req(imem_req), .imem_ready(imem_ready),
    .ir_load(ir_load), .opcode(opcode),
    .BLT(BLT), .BEQ(BEQ),
    .PCbranch(PCbranch), .PCincr(PCincr),
    .EXE_CMD(EXE_CMD), .ImSel(ImSel),
    .Reg_w(Reg_w), .branchEn(branchEn),
    .busy(busy), .fault(fault),
    .state(state), .instr_count(instr_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [2:0] op;
    logic       blt;
    logic       beq;
  } instr_t;

  typedef struct {
    logic [2:0] alu;
    logic       imm;
    logic       wr;
    logic       br_en;
    logic       jump;
    logic       inc;
    int         cnt;
  } exp_t;

  instr_t prog_q[$];
  exp_t   sb_q[$];
  int errors = 0;
  int checks = 0;
  int model_cnt = 0;
  int retires = 0;
  int regw_pulses = 0;
  int inc_pulses = 0;
  int ready_mode = 0;
  int lows = 0;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic exp_t model(instr_t i);
    exp_t e;
    e = '{default: 0};
    case (i.op)
      OP_ADD:  begin e.alu = ALU_RADD; e.wr = 1; end
      OP_SUB:  begin e.alu = ALU_RSUB; e.wr = 1; end
      OP_SRL:  begin e.alu = ALU_RSRL; e.wr = 1; end
      OP_ADDI: begin e.alu = ALU_RADD; e.wr = 1; e.imm = 1; end
      OP_SLLI: begin e.alu = ALU_RSLL; e.wr = 1; e.imm = 1; end
      OP_BLT:  e.br_en = 1;
      OP_BEQ:  e.br_en = 1;
      default: e.alu = ALU_NOP;
    endcase
    e.jump = (i.op == OP_J) || (i.op == OP_BLT && i.blt)
          || (i.op == OP_BEQ && i.beq);
    e.inc = !e.jump;
    return e;
  endfunction

  // instruction memory + IR: new instruction appears when IR loads
  initial begin
    forever begin
      logic   load;
      instr_t in;
      exp_t   e;
      @(negedge clock);
      load = nReset && ir_load;
      @(posedge clock);
      #1;
      if (load && nReset) begin
        if (prog_q.size() > 0) begin
          in = prog_q.pop_front();
        end else begin
          in.op  = 3'($urandom_range(0, 7));
          in.blt = 1'($urandom_range(0, 1));
          in.beq = 1'($urandom_range(0, 1));
        end
        opcode = in.op;
        BLT = in.blt;
        BEQ = in.beq;
        e = model(in);
        model_cnt = (model_cnt + 1) % (1 << CW);
        e.cnt = model_cnt;
        sb_q.push_back(e);
      end
      case (ready_mode)
        0: imem_ready = 1'b1;
        1: begin
          if (lows >= 5 || $urandom_range(0, 2) != 0) begin
            imem_ready = 1'b1;
            lows = 0;
          end else begin
            imem_ready = 1'b0;
            lows++;
          end
        end
        default: imem_ready = 1'b0;
      endcase
    end
  end

  // monitor: pops the scoreboard on every WRITEBACK cycle
  initial begin
    exp_t       cur;
    logic       ex_seen;
    logic [2:0] ex_alu;
    logic       ex_imm, ex_br, ex_en;
    logic       cnt_pend;
    int         cnt_exp;
    ex_seen = 0;
    cnt_pend = 0;
    cnt_exp = 0;
    ex_alu = 0;
    ex_imm = 0;
    ex_br = 0;
    ex_en = 0;
    forever begin
      @(negedge clock);
      if (!nReset) begin
        cnt_pend = 0;
        ex_seen = 0;
      end else begin
        if (cnt_pend) begin
          chk("instr_count", int'(instr_count), cnt_exp);
          cnt_pend = 0;
        end
        chk("pc_exclusive", int'(PCincr & PCbranch), 0);
        chk("regw_outside_wb", int'(Reg_w && state != 3'd4), 0);
        if (Reg_w) regw_pulses++;
        if (PCincr) inc_pulses++;
        if (state == 3'd3) begin
          ex_seen = 1;
          ex_alu = EXE_CMD;
          ex_imm = ImSel;
          ex_br = PCbranch;
          ex_en = branchEn;
        end
        if (state == 3'd4) begin
          retires++;
          if (sb_q.size() == 0) begin
            chk("retire_without_fetch", 1, 0);
          end else begin
            cur = sb_q.pop_front();
            chk("ex_seen", int'(ex_seen), 1);
            chk("ex_alu", int'(ex_alu), int'(cur.alu));
            chk("ex_imsel", int'(ex_imm), int'(cur.imm));
            chk("ex_pcbranch", int'(ex_br), int'(cur.jump));
            chk("ex_branchen", int'(ex_en), int'(cur.br_en));
            chk("wb_alu", int'(EXE_CMD), int'(cur.alu));
            chk("wb_imsel", int'(ImSel), int'(cur.imm));
            chk("wb_regw", int'(Reg_w), int'(cur.wr));
            chk("wb_pcincr", int'(PCincr), int'(cur.inc));
            chk("wb_pcbranch", int'(PCbranch), 0);
            cnt_pend = 1;
            cnt_exp = cur.cnt;
            ex_seen = 0;
          end
        end
      end
    end
  end

  task automatic do_reset();
    run = 0;
    step = 0;
    halt_req = 0;
    nReset = 0;
    prog_q.delete();
    sb_q.delete();
    model_cnt = 0;
    lows = 0;
    repeat (2) @(posedge clock);
    #1 nReset = 1;
  endtask

  task automatic cyc();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic wait_state(string name, int s, int budget);
    int ok;
    ok = 0;
    for (int c = 0; c < budget && ok == 0; c++) begin
      cyc();
      if (state == 3'(s)) ok = 1;
    end
    chk(name, ok, 1);
  endtask

  task automatic pulse_step();
    @(posedge clock);
    #1 step = 1;
    @(posedge clock);
    #1 step = 0;
  endtask

  initial begin
    int r0, p0, n, bad;
    instr_t in;
    #1 nReset = 0;
    #1;
    chk("rst_state", int'(state), 0);
    chk("rst_count", int'(instr_count), 0);
    chk("rst_imem_req", int'(imem_req), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_fault", int'(fault), 0);
    chk("rst_exe_cmd", int'(EXE_CMD), int'(ALU_NOP));
    chk("rst_regw", int'(Reg_w), 0);
    chk("rst_pcincr", int'(PCincr), 0);

    // free run with ADD, memory always ready
    ready_mode = 0;
    do_reset();
    in = '{op: OP_ADD, blt: 0, beq: 0};
    repeat (4) prog_q.push_back(in);
    run = 1;
    for (int k = 1; k <= 13; k++) begin
      cyc();
      chk("run_state_seq", int'(state), ((k - 1) % 4) + 1);
    end
    chk("run_count_12cyc", int'(instr_count), 3);
    run = 0;
    wait_state("run_stop_idle", 0, 20);

    // single step of ADDI
    do_reset();
    in = '{op: OP_ADDI, blt: 0, beq: 0};
    prog_q.push_back(in);
    r0 = regw_pulses;
    p0 = inc_pulses;
    pulse_step();
    wait_state("step_idle", 0, 20);
    repeat (3) cyc();
    chk("step_stays_idle", int'(state), 0);
    chk("step_count", int'(instr_count), 1);
    chk("step_regw_pulses", regw_pulses - r0, 1);
    chk("step_pcincr_pulses", inc_pulses - p0, 1);

    // BEQ taken then not taken
    in = '{op: OP_BEQ, blt: 0, beq: 1};
    prog_q.push_back(in);
    in = '{op: OP_BEQ, blt: 0, beq: 0};
    prog_q.push_back(in);
    pulse_step();
    wait_state("beq1_idle", 0, 20);
    pulse_step();
    wait_state("beq2_idle", 0, 20);
    chk("beq_count", int'(instr_count), 3);

    // fetch timeout
    ready_mode = 2;
    imem_ready = 0;
    do_reset();
    run = 1;
    n = 0;
    for (int c = 0; c < 40 && state != 3'd5; c++) begin
      cyc();
      if (state == 3'd1 && imem_req) n++;
    end
    chk("fault_fetch_cycles", n, MW);
    chk("fault_state", int'(state), 5);
    chk("fault_flag", int'(fault), 1);
    chk("fault_imem_req", int'(imem_req), 0);
    chk("fault_busy", int'(busy), 0);
    bad = 0;
    for (int c = 0; c < 8; c++) begin
      run = ~run;
      cyc();
      if (state != 3'd5 || !fault) bad++;
    end
    chk("fault_sticky", bad, 0);
    ready_mode = 0;
    do_reset();
    #1;
    chk("fault_cleared", int'(fault), 0);
    chk("fault_rst_state", int'(state), 0);

    // halt during DECODE
    run = 1;
    wait_state("halt_reach_decode", 2, 20);
    halt_req = 1;
    cyc();
    chk("halt_exec", int'(state), 3);
    cyc();
    chk("halt_wb", int'(state), 4);
    cyc();
    chk("halt_idle", int'(state), 0);
    bad = 0;
    for (int c = 0; c < 6; c++) begin
      cyc();
      if (imem_req || state != 3'd0) bad++;
    end
    chk("halt_holds", bad, 0);
    halt_req = 0;
    wait_state("halt_resume", 1, 5);
    run = 0;
    wait_state("halt_final_idle", 0, 30);

    // random traffic, count wraps repeatedly
    ready_mode = 1;
    for (int c = 0; c < 600; c++) begin
      @(posedge clock);
      #1;
      run = ($urandom_range(0, 9) < 7);
      halt_req = ($urandom_range(0, 19) == 0);
      step = ($urandom_range(0, 9) == 0);
    end
    run = 0;
    halt_req = 0;
    step = 0;
    wait_state("rand_idle", 0, 60);
    chk("rand_sb_empty", sb_q.size(), 0);

    // 17 instructions with a 4-bit counter, then async reset in FETCH
    ready_mode = 0;
    do_reset();
    run = 1;
    r0 = retires;
    for (int c = 0; c < 120 && (retires - r0) < 17; c++) begin
      cyc();
      #1;
    end
    chk("wrap_retires", retires - r0, 17);
    @(negedge clock);
    #1;
    chk("wrap_fetch", int'(state), 1);
    chk("wrap_count", int'(instr_count), 1);
    #1 nReset = 0;
    #1;
    chk("async_imem_req", int'(imem_req), 0);
    chk("async_count", int'(instr_count), 0);
    chk("async_state", int'(state), 0);
    chk("async_ir_load", int'(ir_load), 0);
    do_reset();
    repeat (3) cyc();
    chk("final_sb_empty", sb_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
